// File: rtl/nibble_tx_pkg.sv
// nibble_tx_pkg: shared constants and FSM state type for the nibble transmit arbiter
package nibble_tx_pkg;
    localparam int NUM_REQ = 4;
    localparam int WORD_W  = 32;
    localparam int NIB_W   = 4;
    localparam int NIBS    = WORD_W / NIB_W;
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
endpackage

// File: rtl/nibble_tx_arbiter_if.sv
// nibble_tx_arbiter_if: requester and nibble-stream bus of the arbiter
// slave (arbiter side): in req, word, out_ready; out ack, out_valid, out_nib, out_last, out_src, busy
// master (environment side): the same signals with directions reversed
interface nibble_tx_arbiter_if #(
    parameter int NUM_REQ = nibble_tx_pkg::NUM_REQ,
    parameter int WORD_W  = nibble_tx_pkg::WORD_W,
    parameter int NIB_W   = nibble_tx_pkg::NIB_W
);
    localparam int SRC_W = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*WORD_W-1:0] word;
    logic [NUM_REQ-1:0]        ack;
    logic                      out_valid;
    logic                      out_ready;
    logic [NIB_W-1:0]          out_nib;
    logic                      out_last;
    logic [SRC_W-1:0]          out_src;
    logic                      busy;
    modport slave (
        input  req, word, out_ready,
        output ack, out_valid, out_nib, out_last, out_src, busy
    );
    modport master (
        output req, word, out_ready,
        input  ack, out_valid, out_nib, out_last, out_src, busy
    );
endinterface

// File: rtl/nibble_tx_reg.sv
// nibble_tx_reg: enable/clear register with async active-low reset to RST
// ports: clock_i, reset_n_i, en_i (load d_i), clr_i (back to RST, wins over en_i), d_i, q_o
module nibble_tx_reg #(
    parameter int           W   = 1,
    parameter logic [W-1:0] RST = '0
) (
    input  logic         clock_i,
    input  logic         reset_n_i,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    always_ff @(posedge clock_i or negedge reset_n_i)
        if (!reset_n_i) q_o <= RST;
        else if (clr_i) q_o <= RST;
        else if (en_i)  q_o <= d_i;
endmodule

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin search starting just after last_grant
// ports: req (requests), last_grant (previous winner), found (any request), grant_idx (winner)
module rr_picker #(
    parameter int NUM_REQ = nibble_tx_pkg::NUM_REQ,
    localparam int SRC_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SRC_W-1:0]   last_grant,
    output logic               found,
    output logic [SRC_W-1:0]   grant_idx
);
    // Scanning from the farthest offset down leaves the nearest requester as the winner.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--)
            if (req[(int'(last_grant) + k) % NUM_REQ]) begin
                found     = 1'b1;
                grant_idx = SRC_W'((int'(last_grant) + k) % NUM_REQ);
            end
    end
endmodule

// File: rtl/nibble_tx_arbiter.sv
// nibble_tx_arbiter: round-robin arbiter streaming each granted word out LSB nibble first
// ports: clock, reset_n (async active-low), bus (slave modport: req/word in, ack pulse,
//        out_valid/out_ready/out_nib/out_last/out_src stream, busy in SEND and DONE)
module nibble_tx_arbiter #(
    parameter int NUM_REQ = nibble_tx_pkg::NUM_REQ,
    parameter int WORD_W  = nibble_tx_pkg::WORD_W,
    parameter int NIB_W   = nibble_tx_pkg::NIB_W
) (
    input logic                clock,
    input logic                reset_n,
    nibble_tx_arbiter_if.slave bus
);
    import nibble_tx_pkg::*;
    localparam int NIB_CNT = WORD_W / NIB_W;
    localparam int SRC_W   = $clog2(NUM_REQ);
    localparam int IDX_W   = $clog2(NIB_CNT);
    state_t state_q, state_d;
    logic [WORD_W-1:0] word_q;
    logic [SRC_W-1:0]  src_q, lg_q, grant_idx;
    logic [IDX_W-1:0]  idx_q;
    logic              found, grant, hs, last, busy;
    rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
        .req        (bus.req),
        .last_grant (lg_q),
        .found      (found),
        .grant_idx  (grant_idx)
    );
    assign grant = state_q == IDLE && found;
    assign hs    = state_q == SEND && bus.out_ready;
    assign last  = idx_q == IDX_W'(NIB_CNT - 1);
    assign busy  = state_q != IDLE;
    nibble_tx_reg #(.W(WORD_W)) u_word (
        .clock_i(clock), .reset_n_i(reset_n), .en_i(grant), .clr_i(1'b0),
        .d_i(bus.word[WORD_W*grant_idx +: WORD_W]), .q_o(word_q)
    );
    nibble_tx_reg #(.W(SRC_W)) u_src (
        .clock_i(clock), .reset_n_i(reset_n), .en_i(grant), .clr_i(1'b0),
        .d_i(grant_idx), .q_o(src_q)
    );
    // Reset to the top index so requester 0 is searched first.
    nibble_tx_reg #(.W(SRC_W), .RST(SRC_W'(NUM_REQ - 1))) u_lg (
        .clock_i(clock), .reset_n_i(reset_n), .en_i(grant), .clr_i(1'b0),
        .d_i(grant_idx), .q_o(lg_q)
    );
    // The final handshake returns idx to 0 ready for the next word.
    nibble_tx_reg #(.W(IDX_W)) u_idx (
        .clock_i(clock), .reset_n_i(reset_n), .en_i(hs), .clr_i(hs && last),
        .d_i(idx_q + 1'b1), .q_o(idx_q)
    );
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = found ? SEND : IDLE;
            SEND:    state_d = hs && last ? DONE : SEND;
            default: state_d = IDLE;
        endcase
    end
    assign bus.out_valid = state_q == SEND;
    assign bus.out_nib   = state_q == SEND ? word_q[NIB_W*idx_q +: NIB_W] : '0;
    assign bus.out_last  = state_q == SEND && last;
    assign bus.out_src   = busy ? src_q : '0;
    assign bus.busy      = busy;
    assign bus.ack       = state_q == DONE ? NUM_REQ'(1) << src_q : '0;
endmodule

// File: doc/nibble_tx_arbiter.md
NIBBLE_TX_ARBITER -- requirements
Module: nibble_tx_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQ, 4, number of requesters; WORD_W, 32, requester word width; NIB_W, 4, output nibble width.
REQ-002 Port clock  input  1  rising-edge system clock, the block's only clock.
REQ-003 Port reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port req  input  NUM_REQ  per-requester transfer request, level-sensitive.
REQ-005 Port word  input  NUM_REQ*WORD_W  flattened request words; requester i occupies bits [WORD_W*i+WORD_W-1 : WORD_W*i].
REQ-006 Port ack  output  NUM_REQ  one-hot, one-cycle completion pulse to the served requester.
REQ-007 Port out_valid  output  1  out_nib is valid.
REQ-008 Port out_ready  input  1  sink accepts out_nib.
REQ-009 Port out_nib  output  NIB_W  current nibble.
REQ-010 Port out_last  output  1  current nibble is the final nibble of the word.
REQ-011 Port out_src  output  clog2(NUM_REQ)  index of the requester being served.
REQ-012 Port busy  output  1  high in SEND and DONE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SEND and DONE.
REQ-014 In IDLE with any req bit high, the block SHALL grant round-robin, searching from (last_grant+1) mod NUM_REQ upward with wrap.
REQ-015 On a grant, the block SHALL latch word[granted], the source index and last_grant at the clock edge, then enter SEND.
REQ-016 Grant-to-first-valid latency SHALL be 1 cycle: req high in IDLE at cycle 0 gives out_valid=1 at cycle 1.
REQ-017 In SEND, out_valid SHALL be 1 and out_nib SHALL be latched_word[NIB_W*idx+NIB_W-1 : NIB_W*idx], with idx starting at 0 (LSB nibble first).
REQ-018 idx SHALL advance only when out_valid && out_ready are both high.
REQ-019 While out_ready is low, out_nib, out_last and out_src SHALL hold stable.
REQ-020 out_last SHALL be 1 exactly when idx = WORD_W/NIB_W-1.
REQ-021 A handshake on the last nibble SHALL move the FSM to DONE and reset idx to 0.
REQ-022 In DONE, ack[src] SHALL be 1 for exactly one cycle, out_valid SHALL be 0, no grant SHALL occur, and the next state SHALL be IDLE.
REQ-023 Changes to req or word after a grant SHALL be ignored until DONE; a withdrawn request still completes and is acked.
REQ-024 A requester holding req high through ack SHALL be treated as making a new request.
REQ-025 If no req bit is high in IDLE, the block SHALL stay in IDLE with all outputs at their reset values.
REQ-026 With out_ready held high, one transaction SHALL take WORD_W/NIB_W+2 cycles (10 at the defaults).

Reset
REQ-027 While reset_n=0, the block SHALL force state=IDLE, idx=0, latched word=0, src=0 and last_grant=NUM_REQ-1, so requester 0 has first priority.
REQ-028 While reset_n=0, out_valid, out_last, busy, ack and out_nib SHALL all be 0.
REQ-029 Reset asserted mid-SEND SHALL abort the transfer with no ack; after reset the block SHALL resume in IDLE.

Structure
REQ-030 Package nibble_tx_pkg SHALL hold the state enum (IDLE, SEND, DONE) and the constants NUM_REQ, WORD_W, NIB_W and NIBS=WORD_W/NIB_W.
REQ-031 Round-robin selection SHALL be a single sub-module, rr_picker (inputs req and last_grant; outputs found and grant_idx), which is purely combinational.
REQ-032 The latched word, idx, src and last_grant SHALL use the team's register module, with its en and clear inputs driven by the FSM.

Verification
REQ-033 Single request: reset, then req=4'b0001 with word0=32'h8765_4321 and out_ready=1 -> out_nib 1,2,3,4,5,6,7,8 on cycles 1-8, out_last on cycle 8, ack=4'b0001 on cycle 9.
REQ-034 Round-robin fairness: req=4'b1111 held high -> grants in order 0,1,2,3,0, one ack per 10 cycles.
REQ-035 Backpressure: out_ready low for 3 cycles at idx=2 -> out_nib holds 3 throughout, no nibble lost or duplicated, ack delayed by 3 cycles.
REQ-036 Withdrawal and word change: drop req0 and change word0 to 32'hFFFF_FFFF at cycle 3 -> the original nibbles still complete and ack0 still pulses.
REQ-037 Reset mid-transfer: pull reset_n low at idx=5 -> out_valid=0 and no ack; after release with req=4'b0010, requester 1 is served with out_src=1.
REQ-038 Pointer wrap: last_grant=3, then req=4'b1001 -> requester 0 is granted first and requester 3 next.
